// File: rtl/led_pattern_scheduler.sv
// led_pattern_scheduler: steps active-low LEDs through idle/chase/bounce/blink.
// Define LED_PWM_DIM_EN to add a brightness input and PWM dimming of lit LEDs.
module led_pattern_scheduler #(
  parameter int STEP_CYCLES = 1200000,
  parameter int NUM_LEDS    = 8
`ifdef LED_PWM_DIM_EN
  ,
  parameter int PWM_BITS    = 4
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  input  logic [1:0]                  req_mode,
  output logic                        req_ready,
  input  logic                        pause,
`ifdef LED_PWM_DIM_EN
  input  logic [PWM_BITS-1:0]         brightness,
`endif
  output logic [NUM_LEDS-1:0]         led_n,
  output logic                        step_tick,
  output logic [$clog2(NUM_LEDS)-1:0] pos
);
  localparam int PW = $clog2(NUM_LEDS);
  localparam int CW = $clog2(STEP_CYCLES);
  localparam logic [CW-1:0] TC   = CW'(STEP_CYCLES - 1);
  localparam logic [PW-1:0] PMAX = PW'(NUM_LEDS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHASE  = 2'd1,
    BOUNCE = 2'd2,
    BLINK  = 2'd3
  } state_t;

  state_t        state, nxt_state;
  logic [CW-1:0] presc, nxt_presc;
  logic [PW-1:0] nxt_pos;
  logic          pend_valid, nxt_pv;
  logic [1:0]    pend_mode, nxt_pm;
  logic          dir, nxt_dir;
  logic          phase, nxt_phase;
  logic          nxt_tick, nxt_ready;
  logic          tc, dim_on;

  function automatic logic [NUM_LEDS-1:0] lit_of(
    input state_t s, input logic [PW-1:0] p, input logic ph);
    logic [NUM_LEDS-1:0] m;
    m = '0;
    case (s)
      CHASE, BOUNCE: m[p] = 1'b1;
      BLINK:         m = ph ? '0 : '1;
      default:       m = '0;
    endcase
    return m;
  endfunction

`ifdef LED_PWM_DIM_EN
  logic [PWM_BITS-1:0] pwm_cnt;
  assign dim_on = (pwm_cnt < brightness);

  // Free-running dimming counter; keeps running while paused.
  always_ff @(posedge clk) begin
    if (rst) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_cnt + PWM_BITS'(1);
  end
`else
  assign dim_on = 1'b1;
`endif

  assign tc = (presc == TC);

  // Next-state: prescaler, mode apply on step boundaries, pattern stepping.
  always_comb begin
    nxt_state = state;
    nxt_presc = presc;
    nxt_pos   = pos;
    nxt_dir   = dir;
    nxt_phase = phase;
    nxt_tick  = 1'b0;
    nxt_pv    = pend_valid;
    nxt_pm    = pend_mode;
    nxt_ready = req_ready;
    if (!pause) begin
      nxt_presc = tc ? '0 : presc + CW'(1);
      if (pend_valid && (state == IDLE || tc)) begin
        nxt_state = state_t'(pend_mode);
        nxt_pos   = '0;
        nxt_dir   = 1'b0;
        nxt_phase = 1'b0;
        nxt_pv    = 1'b0;
        nxt_ready = 1'b1;
        nxt_tick  = tc && (state != IDLE);
        if (state == IDLE) nxt_presc = '0;
      end else if (tc && state != IDLE) begin
        nxt_tick = 1'b1;
        case (state)
          CHASE: nxt_pos = (pos == PMAX) ? '0 : pos + PW'(1);
          BOUNCE: begin
            if (!dir) begin
              if (pos == PMAX) begin
                nxt_pos = pos - PW'(1);
                nxt_dir = 1'b1;
              end else begin
                nxt_pos = pos + PW'(1);
              end
            end else begin
              if (pos == '0) begin
                nxt_pos = PW'(1);
                nxt_dir = 1'b0;
              end else begin
                nxt_pos = pos - PW'(1);
              end
            end
          end
          BLINK:   nxt_phase = ~phase;
          default: nxt_pos = pos;
        endcase
      end
    end
    if (req_valid && req_ready) begin
      nxt_pv    = 1'b1;
      nxt_pm    = req_mode;
      nxt_ready = 1'b0;
    end
  end

  // Pattern FSM with registered outputs; reset dominates.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      presc      <= '0;
      pos        <= '0;
      dir        <= 1'b0;
      phase      <= 1'b0;
      pend_valid <= 1'b0;
      pend_mode  <= 2'd0;
      req_ready  <= 1'b1;
      step_tick  <= 1'b0;
      led_n      <= '1;
    end else begin
      state      <= nxt_state;
      presc      <= nxt_presc;
      pos        <= nxt_pos;
      dir        <= nxt_dir;
      phase      <= nxt_phase;
      pend_valid <= nxt_pv;
      pend_mode  <= nxt_pm;
      req_ready  <= nxt_ready;
      step_tick  <= nxt_tick;
      led_n      <= ~(lit_of(nxt_state, nxt_pos, nxt_phase)
                      & {NUM_LEDS{dim_on}});
    end
  end

endmodule

// File: tb/tb_led_pattern_scheduler.sv
// tb_led_pattern_scheduler: directed vectors for led_pattern_scheduler.
// STEP_CYCLES=4, NUM_LEDS=8; PWM checks only when LED_PWM_DIM_EN is set.
module tb_led_pattern_scheduler;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_mode = 2'd0;
  logic       req_ready;
  logic       pause = 1'b0;
  logic [7:0] led_n;
  logic       step_tick;
  logic [2:0] pos;
`ifdef LED_PWM_DIM_EN
  logic [3:0] brightness = 4'd15;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  led_pattern_scheduler #(
    .STEP_CYCLES(4),
    .NUM_LEDS(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_mode(req_mode),
    .req_ready(req_ready),
    .pause(pause),
`ifdef LED_PWM_DIM_EN
    .brightness(brightness),
`endif
    .led_n(led_n),
    .step_tick(step_tick),
    .pos(pos)
  );

  typedef struct {
    logic       v;
    logic [1:0] m;
    logic [7:0] led;
    logic [2:0] p;
    logic       tk;
    logic       rdy;
  } vec_t;

  vec_t tbl[11];
  int   bexp[17];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_tick(input int gap, input logic [7:0] e_led,
                           input logic [2:0] e_pos, input string nm);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!step_tick && k < 50);
    chk({nm, "_gap"}, k, gap);
    chk({nm, "_led"}, led_n, e_led);
    chk({nm, "_pos"}, pos, e_pos);
  endtask

  task automatic req(input logic [1:0] m);
    req_valid = 1'b1;
    req_mode  = m;
    @(negedge clk);
    chk("req_accept", req_ready, 1'b0);
    req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] e;
    int on;
    tbl[0]  = '{1'b1, 2'd1, 8'hFF, 3'd0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 2'd0, 8'hFF, 3'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 2'd0, 8'hFE, 3'd0, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 2'd0, 8'hFE, 3'd0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 2'd0, 8'hFE, 3'd0, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 2'd0, 8'hFE, 3'd0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 2'd0, 8'hFD, 3'd1, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 2'd0, 8'hFD, 3'd1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 2'd0, 8'hFD, 3'd1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 2'd0, 8'hFD, 3'd1, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 2'd0, 8'hFB, 3'd2, 1'b1, 1'b1};
    bexp = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};

    repeat (3) @(negedge clk);
    rst = 1'b0;

`ifdef LED_PWM_DIM_EN
    chk("pwm_rst_led", led_n, 8'hFF);
    brightness = 4'd4;
    req_valid = 1'b1;
    req_mode  = 2'd1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    pause = 1'b1;
    repeat (2) @(negedge clk);
    on = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (led_n[0] == 1'b0) on++;
      chk("pwm_others", led_n[7:1], 7'h7F);
    end
    chk("pwm_duty4", on, 4);
    brightness = 4'd0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("pwm_dark", led_n, 8'hFF);
    end
`else
    for (int i = 0; i < 11; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("vec%0d_led", i), led_n, tbl[i].led);
      chk($sformatf("vec%0d_pos", i), pos, tbl[i].p);
      chk($sformatf("vec%0d_tick", i), step_tick, tbl[i].tk);
      chk($sformatf("vec%0d_rdy", i), req_ready, tbl[i].rdy);
      req_valid = tbl[i].v;
      req_mode  = tbl[i].m;
    end

    for (int s = 3; s < 10; s++) begin
      e = ~(8'h01 << (s % 8));
      wait_tick(4, e, 3'(s % 8), "chase");
    end

    req(2'd2);
    wait_tick(3, 8'hFE, 3'd0, "bounce_apply");
    for (int i = 1; i < 17; i++) begin
      e = ~(8'h01 << bexp[i]);
      wait_tick(4, e, 3'(bexp[i]), "bounce");
    end

    req(2'd1);
    wait_tick(3, 8'hFE, 3'd0, "chase_apply");
    wait_tick(4, 8'hFD, 3'd1, "chase_step");
    req(2'd3);
    chk("blink_not_early", led_n, 8'hFD);
    wait_tick(3, 8'h00, 3'd0, "blink_apply");
    wait_tick(4, 8'hFF, 3'd0, "blink_off");
    wait_tick(4, 8'h00, 3'd0, "blink_on");

    repeat (3) @(negedge clk);
    req_valid = 1'b1;
    req_mode  = 2'd1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("tc_acc_tick", step_tick, 1'b1);
    chk("tc_acc_led", led_n, 8'hFF);
    chk("tc_acc_rdy", req_ready, 1'b0);
    wait_tick(4, 8'hFE, 3'd0, "tc_acc_apply");
    chk("tc_acc_rdy_back", req_ready, 1'b1);

    req_valid = 1'b1;
    req_mode  = 2'd2;
    @(negedge clk);
    chk("hs_first_acc", req_ready, 1'b0);
    req_mode = 2'd3;
    @(negedge clk);
    chk("hs_full_rdy", req_ready, 1'b0);
    wait_tick(2, 8'hFE, 3'd0, "hs_first_apply");
    chk("hs_rdy_back", req_ready, 1'b1);
    @(negedge clk);
    chk("hs_second_acc", req_ready, 1'b0);
    req_valid = 1'b0;
    wait_tick(3, 8'h00, 3'd0, "hs_second_apply");

    req(2'd1);
    wait_tick(3, 8'hFE, 3'd0, "p_chase");
    wait_tick(4, 8'hFD, 3'd1, "p_step");
    repeat (2) @(negedge clk);
    pause = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("pause_led", led_n, 8'hFD);
      chk("pause_pos", pos, 3'd1);
      chk("pause_tick", step_tick, 1'b0);
      if (i == 5) chk("pause_acc", req_ready, 1'b0);
      req_valid = (i == 4);
      req_mode  = 2'd2;
    end
    pause = 1'b0;
    wait_tick(2, 8'hFE, 3'd0, "pause_apply");

    wait_tick(4, 8'hFD, 3'd1, "same_a");
    wait_tick(4, 8'hFB, 3'd2, "same_b");
    req(2'd2);
    wait_tick(3, 8'hFE, 3'd0, "same_restart");

    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_led", led_n, 8'hFF);
    chk("rst_pos", pos, 3'd0);
    chk("rst_rdy", req_ready, 1'b1);
    chk("rst_tick", step_tick, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_led", led_n, 8'hFF);
      chk("idle_tick", step_tick, 1'b0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
